ra_sample_capture: RTL and testbench

Front-end stage that feeds the rolling-average core. It synchronises the asynchronous sample strobe `i_data_clk` and the sample bus into the `clk` domain, then captures one word per strobe rising edge. Captured words are buffered in a small FIFO and presented to the averager over a valid/ready interface.

---
 rtl/ra_pkg.sv | 14 +
 rtl/ra_sync.sv | 31 +++
 rtl/ra_sample_capture.sv | 114 +++++++++++
 tb/tb_ra_sample_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ra_pkg.sv
// rtl/ra_pkg.sv - shared rolling-average element constants, sample type and width helper
package ra_pkg;

   // Element width shared by the capture stage and the averager.
   localparam int BITS_PER_ELEM = 5;

   typedef logic [BITS_PER_ELEM-1:0] sample_t;

   // Width needed to hold an occupancy value of 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ra_sync.sv
// rtl/ra_sync.sv - generic N-stage, W-wide synchroniser with async active-low reset
//
// Ports:
//   clk  destination clock
//   rst  asynchronous active-low reset, clears every stage
//   d    asynchronous input
//   q    output of the last stage
module ra_sync #(
   parameter int STAGES = 2,
   parameter int W      = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] chain [STAGES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/ra_sample_capture.sv
// rtl/ra_sample_capture.sv - synchronise async sample strobe/bus, capture on strobe rise into a FIFO
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   i_data_clk  asynchronous sample strobe, rising edge marks a new sample
//   i_data      asynchronous sample bus
//   i_ready     downstream accepts the head word this cycle
//   o_valid     FIFO non-empty, o_data valid
//   o_data      head-of-FIFO sample (0 when empty)
//   o_count     current FIFO occupancy
//   o_overflow  sticky: at least one sample dropped
module ra_sample_capture
   import ra_pkg::*;
#(
   parameter int BITS_PER_ELEM = ra_pkg::BITS_PER_ELEM,
   parameter int SYNC_STAGES   = 2,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                i_data_clk,
   input  logic [BITS_PER_ELEM-1:0]            i_data,
   input  logic                                i_ready,
   output logic                                o_valid,
   output logic [BITS_PER_ELEM-1:0]            o_data,
   output logic [count_width(FIFO_DEPTH)-1:0]  o_count,
   output logic                                o_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = count_width(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic                     sync_clk;
   logic [BITS_PER_ELEM-1:0] sync_data;

   // Identical chains keep the strobe and the bus aligned in time.
   ra_sync #(.STAGES(SYNC_STAGES), .W(1)) u_sync_clk (
      .clk (clk),
      .rst (rst),
      .d   (i_data_clk),
      .q   (sync_clk)
   );

   ra_sync #(.STAGES(SYNC_STAGES), .W(BITS_PER_ELEM)) u_sync_data (
      .clk (clk),
      .rst (rst),
      .d   (i_data),
      .q   (sync_data)
   );

   // fill[k] marks that chain stage k holds a real post-reset sample. The
   // reset zeros in the chain are not a genuine low level, so they must not
   // arm the detector; otherwise a strobe held high across reset release
   // would look like a fresh rising edge.
   logic [SYNC_STAGES-1:0] fill;
   logic                   prev;
   logic                   armed;
   logic                   rise;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill  <= '0;
         prev  <= 1'b0;
         armed <= 1'b0;
      end else begin
         fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
         prev  <= sync_clk;
         if (fill[SYNC_STAGES-1] && !sync_clk) armed <= 1'b1;
      end
   end

   assign rise = sync_clk & ~prev & armed;

   // FIFO: wrapping pointers, separate occupancy counter.
   logic [BITS_PER_ELEM-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [CNT_W-1:0]         count;
   logic                     full;
   logic                     push;
   logic                     pop;

   assign full = (count == DEPTH_C);
   assign pop  = o_valid & i_ready;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign push = rise & (~full | pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
         if (rise && full && !pop) o_overflow <= 1'b1;
      end
   end

   // Storage is deliberately left unreset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= sync_data;
   end

   assign o_valid = (count != '0);
   assign o_data  = o_valid ? mem[rd_ptr] : '0;
   assign o_count = count;

endmodule

// File: tb/tb_ra_sample_capture.sv
// tb/tb_ra_sample_capture.sv - scoreboard bench for ra_sample_capture
module tb_ra_sample_capture;
   import ra_pkg::*;

   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_data_clk = 1'b0;
   sample_t       i_data = '0;
   logic          i_ready = 1'b0;
   logic          o_valid;
   sample_t       o_data;
   logic [2:0]    o_count;
   logic          o_overflow;

   ra_sample_capture #(
      .BITS_PER_ELEM (BITS_PER_ELEM),
      .SYNC_STAGES   (2),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_data_clk (i_data_clk),
      .i_data     (i_data),
      .i_ready    (i_ready),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_count    (o_count),
      .o_overflow (o_overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int      due;
      sample_t data;
   } pend_t;

   pend_t   pend[$];     // samples issued, waiting for their push edge
   sample_t model_q[$];  // reference FIFO contents
   bit      model_ovf = 1'b0;
   int      total = 0;
   int      bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor / reference model: compare, then advance the model across the
   // coming clock edge using the inputs the DUT will sample there.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_valid", o_valid, 0);
         chk("rst_data", o_data, 0);
         chk("rst_count", o_count, 0);
         chk("rst_ovf", o_overflow, 0);
         model_q.delete();
         pend.delete();
         model_ovf = 1'b0;
      end else begin
         int  sz;
         bit  pop;
         sz = model_q.size();
         chk("valid", o_valid, (sz != 0) ? 1 : 0);
         chk("count", o_count, sz);
         chk("data", o_data, (sz != 0) ? int'(model_q[0]) : 0);
         chk("overflow", o_overflow, model_ovf);
         pop = (sz != 0) && i_ready;
         if (pop) begin
            chk("pop_word", o_data, model_q[0]);
            void'(model_q.pop_front());
         end
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            chk("stale_pending", pend[0].due, cyc + 1);
            void'(pend.pop_front());
         end
         if (pend.size() != 0 && pend[0].due == cyc + 1) begin
            if (sz < DEPTH || pop) model_q.push_back(pend[0].data);
            else model_ovf = 1'b1;
            void'(pend.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Data set one cycle ahead of the rise and held at least 4 cycles after it.
   task automatic strobe(input sample_t d, input int hi, input int lo, input bit exp_sample);
      pend_t p;
      i_data = d;
      tick(1);
      i_data_clk = 1'b1;
      p.due  = cyc + 3;
      p.data = d;
      if (exp_sample) pend.push_back(p);
      tick(hi);
      i_data_clk = 1'b0;
      tick(lo);
   endtask

   initial begin
      bit done;
      pend_t p;

      // Reset with the strobe toggling.
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         i_data_clk = ~i_data_clk;
         i_data = sample_t'(i + 7);
         tick(1);
      end
      i_data_clk = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(6);

      // Single sample then one-cycle pop.
      strobe(5'h13, 2, 3, 1'b1);
      tick(2);
      i_ready = 1'b1;
      tick(1);
      i_ready = 1'b0;
      tick(3);

      // Overflow: five samples into a 4-deep FIFO, then drain.
      for (int i = 1; i <= 5; i++) strobe(sample_t'(i), 2, 2, 1'b1);
      tick(3);
      i_ready = 1'b1;
      tick(8);
      i_ready = 1'b0;
      tick(2);

      // Clear the sticky flag, then full + simultaneous push/pop.
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(4);
      for (int i = 0; i < 4; i++) strobe(sample_t'(5'h10 + i), 2, 2, 1'b1);
      tick(2);
      i_data = 5'h1A;
      tick(1);
      i_data_clk = 1'b1;
      p.due  = cyc + 3;
      p.data = 5'h1A;
      pend.push_back(p);
      tick(2);
      i_ready = 1'b1;        // pop lands on the push edge
      tick(1);
      i_data_clk = 1'b0;
      tick(8);
      i_ready = 1'b0;
      tick(2);

      // Strobe held high for 20 cycles gives one sample.
      strobe(5'h0B, 20, 3, 1'b1);
      i_ready = 1'b1;
      tick(3);
      i_ready = 1'b0;

      // Strobe high across reset release: nothing until a fresh rise.
      rst = 1'b0;
      i_data = 5'h0F;
      i_data_clk = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(8);
      i_data_clk = 1'b0;
      tick(3);
      strobe(5'h0E, 2, 3, 1'b1);
      i_ready = 1'b1;
      tick(3);

      // Pointer wrap with continuous ready.
      for (int i = 0; i < 12; i++) strobe(sample_t'(i), 2, 2, 1'b1);
      tick(4);

      // Randomised strobes and ready.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++)
               strobe(sample_t'($urandom_range(0, 31)), $urandom_range(2, 5),
                      $urandom_range(2, 5), 1'b1);
            done = 1'b1;
         end
         begin
            while (!done) begin
               i_ready = ($urandom_range(0, 3) == 0);
               tick(1);
            end
         end
      join
      i_ready = 1'b1;
      tick(10);

      chk("pending_empty", pend.size(), 0);
      chk("final_count", o_count, 0);
      chk("final_valid", o_valid, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
